// File: rtl/count16_pkg.sv
// Shared processor constants: cycle-count defaults used by count16 and the mult/div units.
package count16_pkg;

   localparam int TERMINAL_DEF = 16;
   localparam int CNT_W_DEF    = 5;

   // The counter must be able to represent TERMINAL without wrapping.
   function automatic bit cnt_w_ok(input int terminal, input int cnt_w);
      return ((64'd1 << cnt_w) > 64'(terminal));
   endfunction

endpackage

// File: rtl/count16_if.sv
// Status bundle of count16: done/enable strobes plus the live count for observability.
interface count16_if
   import count16_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             done;
   logic             enable;
   logic [CNT_W-1:0] count;

   modport master (output done, output enable, output count);
   modport slave  (input  done, input  enable, input  count);
endinterface

// File: rtl/count16_dffe_ar.sv
// Single D flip-flop with load enable and asynchronous active-low clear.
module dffe_ar (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic d,
   output logic q
);

   logic q_q;
   logic q_d;

   // An unknown enable falls through to hold, so an X reset cannot advance the count.
   always_comb begin
      q_d = q_q;
      if (en) q_d = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= 1'b0;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/count16.sv
// Saturating cycle counter: done rises TERMINAL edges after reset release and stays high.
module count16
   import count16_pkg::*;
#(
   parameter int TERMINAL = TERMINAL_DEF,
   parameter int CNT_W    = CNT_W_DEF
)(
   output logic      done,
   input  logic      clock,
   input  logic      reset,
   output logic      enable,
   count16_if.master stat
);

   localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERMINAL);

   if (!cnt_w_ok(TERMINAL, CNT_W)) begin : g_bad_width
      $error("count16: CNT_W too narrow for TERMINAL");
   end

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             at_term;
   logic             cnt_en;

   always_comb begin
      at_term = (count_q == TERM_C);
      count_d = count_q + CNT_W'(1);
      cnt_en  = reset & ~at_term;
   end

   for (genvar i = 0; i < CNT_W; i++) begin : g_bit
      dffe_ar u_bit (
         .clk   (clock),
         .rst_n (reset),
         .en    (cnt_en),
         .d     (count_d[i]),
         .q     (count_q[i])
      );
   end

   assign done   = at_term;
   assign enable = ~at_term;

   assign stat.done   = done;
   assign stat.enable = enable;
   assign stat.count  = count_q;

endmodule

// File: tb/tb_count16.sv
// Directed bench for count16: default instance (16) and an override instance (TERMINAL=4, CNT_W=3).
module tb_count16;

   logic clk;
   logic rst_a;
   logic rst_b;
   logic done_a, enable_a;
   logic done_b, enable_b;

   int checks = 0;
   int errors = 0;

   count16_if #(.CNT_W(5)) if_a ();
   count16_if #(.CNT_W(3)) if_b ();

   count16 u_dut_a (
      .done   (done_a),
      .clock  (clk),
      .reset  (rst_a),
      .enable (enable_a),
      .stat   (if_a)
   );

   count16 #(.TERMINAL(4), .CNT_W(3)) u_dut_b (
      .done   (done_b),
      .clock  (clk),
      .reset  (rst_b),
      .enable (enable_b),
      .stat   (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] exp_a;
      logic [4:0] exp_b;
   } vec_t;

   vec_t vecs [24];

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   // Compare both instances against the expected counts right now.
   task automatic cmp_now(input string tag, input logic [4:0] ea, input logic [4:0] eb);
      chk({tag, " a.done"},   {7'd0, done_a},   {7'd0, ea == 5'd16});
      chk({tag, " a.enable"}, {7'd0, enable_a}, {7'd0, ea != 5'd16});
      chk({tag, " a.count"},  {3'd0, if_a.count}, {3'd0, ea});
      chk({tag, " a.if_done"}, {7'd0, if_a.done}, {7'd0, ea == 5'd16});
      chk({tag, " b.done"},   {7'd0, done_b},   {7'd0, eb == 5'd4});
      chk({tag, " b.enable"}, {7'd0, enable_b}, {7'd0, eb != 5'd4});
      chk({tag, " b.count"},  {5'd0, if_b.count}, {3'd0, eb});
   endtask

   task automatic edge_chk(input string tag, input logic [4:0] ea, input logic [4:0] eb);
      @(posedge clk);
      #1;
      cmp_now(tag, ea, eb);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Edge k after release: default counts k up to 16, override counts k up to 4.
      for (int i = 0; i < 24; i++) begin
         vecs[i].exp_a = (i + 1 < 16) ? 5'(i + 1) : 5'd16;
         vecs[i].exp_b = (i + 1 < 4)  ? 5'(i + 1) : 5'd4;
      end

      rst_a = 1'b0;
      rst_b = 1'b0;
      #1;
      cmp_now("reset", 5'd0, 5'd0);
      #2;
      rst_a = 1'b1;
      rst_b = 1'b1;

      for (int i = 0; i < 24; i++)
         edge_chk($sformatf("run e%0d", i + 1), vecs[i].exp_a, vecs[i].exp_b);

      // Short reset pulse while done is high clears immediately, no clock edge.
      #2;
      rst_a = 1'b0;
      #1;
      cmp_now("pulse_done", 5'd0, 5'd4);
      #1;
      rst_a = 1'b1;
      for (int i = 1; i <= 18; i++)
         edge_chk($sformatf("after_pulse e%0d", i), (i < 16) ? 5'(i) : 5'd16, 5'd4);

      // Mid-count abort at edge 8.
      #2;
      rst_a = 1'b0;
      #1;
      rst_a = 1'b1;
      for (int i = 1; i <= 8; i++)
         edge_chk($sformatf("pre_abort e%0d", i), 5'(i), 5'd4);
      #2;
      rst_a = 1'b0;
      #1;
      cmp_now("abort", 5'd0, 5'd4);
      #1;
      rst_a = 1'b1;
      for (int i = 1; i <= 17; i++)
         edge_chk($sformatf("post_abort e%0d", i), (i < 16) ? 5'(i) : 5'd16, 5'd4);

      // Reset held low across 10 edges.
      #2;
      rst_a = 1'b0;
      for (int i = 1; i <= 10; i++)
         edge_chk($sformatf("held e%0d", i), 5'd0, 5'd4);
      #2;
      rst_a = 1'b1;
      for (int i = 1; i <= 3; i++)
         edge_chk($sformatf("rel e%0d", i), 5'(i), 5'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/count16.md
COUNT16 -- requirements
Module: count16

Interface
REQ-001 Parameter TERMINAL, default 16, number of counted clock cycles before done asserts.
REQ-002 Parameter CNT_W, default 5, counter width; SHALL satisfy 2^CNT_W > TERMINAL.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 done  output  1  high once TERMINAL rising edges have elapsed since reset release.
REQ-006 enable  output  1  high while counting is in progress; the client unit's "keep running" strobe.
REQ-007 Port order SHALL be done, clock, reset, enable for positional instantiation.

Function
REQ-008 Internal register count[CNT_W-1:0] SHALL be the only sequential state.
REQ-009 On each rising clock edge with reset high and count < TERMINAL, count SHALL increment by 1.
REQ-010 When count == TERMINAL, count SHALL hold; it SHALL never wrap or exceed TERMINAL.
REQ-011 done SHALL equal (count == TERMINAL), decoded combinationally from the register, glitch-free relative to clock.
REQ-012 enable SHALL equal NOT done, with no added latency.
REQ-013 Latency: done rises after exactly TERMINAL rising edges following reset deassertion (16 by default).
REQ-014 done is sticky: it SHALL stay high until the next reset assertion.
REQ-015 Reset asserted mid-count SHALL abort the count immediately, with no clock needed; counting restarts from 0 on release.
REQ-016 No other input SHALL affect count; an unknown reset SHALL NOT cause count to advance in simulation.

Reset
REQ-017 While reset is low: count = 0, done = 0, enable = 1, independent of clock.
REQ-018 Reset assertion SHALL be asynchronous; deassertion SHALL be treated as synchronous to clock (the system meets recovery/removal timing; no internal synchronizer).
REQ-019 A reset pulse shorter than one clock period SHALL still clear count fully.

Structure
REQ-020 TERMINAL and CNT_W defaults SHALL live in the shared processor constants package, used also by the mult/div units.
REQ-021 One sub-module, dffe_ar (D flip-flop with enable and asynchronous clear), SHALL be instantiated CNT_W times for the count register.
REQ-022 Incrementer and terminal comparator SHALL be combinational logic inside count16; no behavioural counters outside the sub-module.

Verification
REQ-023 Reset low for 3 ns, then released; run 20 clock periods (10 ns period) -> done = 0, enable = 1 on edges 1-15; done = 1, enable = 0 from edge 16 onward; count stays 16.
REQ-024 Reset pulse at edge 8 mid-count -> done = 0, enable = 1 immediately; done rises 16 edges after release.
REQ-025 Reset pulse while done = 1 (for example at 200 ns) -> done = 0 and enable = 1 asynchronously; after release, done returns after exactly 16 edges.
REQ-026 Hold reset low for 10 edges -> count stays 0, done = 0, enable = 1 throughout.
REQ-027 Parameter override TERMINAL = 4, CNT_W = 3 -> done asserts on edge 4 and holds; no wrap after 20 further edges.
REQ-028 Self-checking bench SHALL compare done and enable against a reference cycle counter 1 ns after every rising edge and report any mismatch.
